// File: rtl/xillybus_loopback_fifo_32.sv
// xillybus_loopback_fifo_32: loopback FIFO that sinks the write_32 stream (wren/data/full/open) and serves the read_32 stream (rden/data/empty/eof/open), with fill_level and sticky overflow/underflow
module xillybus_loopback_fifo_32 #(
  parameter int DEPTH_LOG2 = 9
) (
  input  logic                  bus_clk,
  input  logic                  bus_rst,
  input  logic                  user_w_write_32_wren,
  input  logic [31:0]           user_w_write_32_data,
  input  logic                  user_w_write_32_open,
  output logic                  user_w_write_32_full,
  input  logic                  user_r_read_32_rden,
  input  logic                  user_r_read_32_open,
  output logic [31:0]           user_r_read_32_data,
  output logic                  user_r_read_32_empty,
  output logic                  user_r_read_32_eof,
  output logic [DEPTH_LOG2:0]   fill_level,
  output logic                  overflow,
  output logic                  underflow
);
  logic [31:0] mem [2**DEPTH_LOG2];
  logic [DEPTH_LOG2:0] wr_ptr, rd_ptr;
  logic w_open_q, r_open_q, writer_closed, wr_acc, rd_acc, flush;
  assign fill_level = wr_ptr - rd_ptr;
  assign user_w_write_32_full = fill_level[DEPTH_LOG2];
  assign user_r_read_32_empty = fill_level == '0;
  assign flush = r_open_q & ~user_r_read_32_open;
  assign wr_acc = user_w_write_32_wren & ~user_w_write_32_full;
  assign rd_acc = user_r_read_32_rden & ~user_r_read_32_empty & ~flush;
  always_ff @(posedge bus_clk)
    if (wr_acc) mem[wr_ptr[DEPTH_LOG2-1:0]] <= user_w_write_32_data;
  always_ff @(posedge bus_clk or posedge bus_rst)
    if (bus_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      user_r_read_32_data <= '0;
      user_r_read_32_eof <= 1'b0;
      overflow <= 1'b0;
      underflow <= 1'b0;
      w_open_q <= 1'b0;
      r_open_q <= 1'b0;
      writer_closed <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + {{DEPTH_LOG2{1'b0}}, wr_acc};
      rd_ptr <= flush ? wr_ptr : rd_ptr + {{DEPTH_LOG2{1'b0}}, rd_acc};
      if (rd_acc) user_r_read_32_data <= mem[rd_ptr[DEPTH_LOG2-1:0]];
      overflow <= overflow | (user_w_write_32_wren & user_w_write_32_full);
      underflow <= underflow | (user_r_read_32_rden & user_r_read_32_empty);
      w_open_q <= user_w_write_32_open;
      r_open_q <= user_r_read_32_open;
      writer_closed <= ~user_r_read_32_open ? 1'b0 :
                       (~w_open_q & user_w_write_32_open) ? 1'b0 :
                       (w_open_q & ~user_w_write_32_open) ? 1'b1 : writer_closed;
      user_r_read_32_eof <= writer_closed & user_r_read_32_empty & ~user_w_write_32_open;
    end
endmodule

// File: tb/tb_xillybus_loopback_fifo_32.sv
// tb_xillybus_loopback_fifo_32: table vectors, queue-model random traffic and corner sequences for the loopback FIFO
module tb_xillybus_loopback_fifo_32;
  logic clk = 1'b0, bus_rst = 1'b0;
  logic wren = 1'b0, rden = 1'b0, w_open = 1'b1, r_open = 1'b1;
  logic [31:0] wdata = '0, data;
  logic full, empty, eof, ov, un;
  logic [9:0] fill;
  int checks = 0, failures = 0;
  logic [31:0] q [$];
  logic [31:0] m_dout, prev;
  bit m_ov, m_un, m_ropen;
  typedef struct {bit we; bit re; logic [31:0] d; logic [31:0] ed; int ef; bit ee;} vec_t;
  vec_t tbl [8];
  xillybus_loopback_fifo_32 #(.DEPTH_LOG2(9)) dut (
    .bus_clk(clk), .bus_rst(bus_rst),
    .user_w_write_32_wren(wren), .user_w_write_32_data(wdata),
    .user_w_write_32_open(w_open), .user_w_write_32_full(full),
    .user_r_read_32_rden(rden), .user_r_read_32_open(r_open),
    .user_r_read_32_data(data), .user_r_read_32_empty(empty),
    .user_r_read_32_eof(eof), .fill_level(fill),
    .overflow(ov), .underflow(un)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", n, a, e);
    end
  endtask
  task automatic rst_dut();
    bus_rst = 1'b1;
    #1;
    chk("rst_full", {31'b0, full}, 0);
    chk("rst_empty", {31'b0, empty}, 1);
    chk("rst_eof", {31'b0, eof}, 0);
    chk("rst_data", data, 0);
    chk("rst_fill", {22'b0, fill}, 0);
    chk("rst_ov", {31'b0, ov}, 0);
    chk("rst_un", {31'b0, un}, 0);
    @(posedge clk);
    #1 bus_rst = 1'b0;
    q.delete();
    m_dout = '0;
    m_ov = 0;
    m_un = 0;
    m_ropen = 0;
  endtask
  task automatic cyc(input bit we, input bit re, input logic [31:0] d);
    bit fl, wr;
    wren = we;
    rden = re;
    wdata = d;
    fl = m_ropen && !r_open;
    if (re && q.size() == 0) m_un = 1;
    if (we && q.size() == 512) m_ov = 1;
    wr = we && q.size() < 512;
    if (fl) q.delete();
    else if (re && q.size() > 0) m_dout = q.pop_front();
    if (wr) q.push_back(d);
    m_ropen = r_open;
    @(posedge clk);
    #1;
    wren = 0;
    rden = 0;
    chk("data", data, m_dout);
    chk("fill", {22'b0, fill}, q.size());
    chk("empty", {31'b0, empty}, q.size() == 0);
    chk("full", {31'b0, full}, q.size() == 512);
    chk("overflow", {31'b0, ov}, m_ov);
    chk("underflow", {31'b0, un}, m_un);
  endtask
  initial begin
    for (int i = 0; i < 4; i++) begin
      tbl[i] = '{1, 0, i + 1, 0, i + 1, 0};
      tbl[i + 4] = '{0, 1, 0, i + 1, 3 - i, i == 3};
    end
    #3;
    rst_dut();
    for (int i = 0; i < 8; i++) begin
      wren = tbl[i].we;
      rden = tbl[i].re;
      wdata = tbl[i].d;
      @(posedge clk);
      #1;
      wren = 0;
      rden = 0;
      chk("tbl_data", data, tbl[i].ed);
      chk("tbl_fill", {22'b0, fill}, tbl[i].ef);
      chk("tbl_empty", {31'b0, empty}, tbl[i].ee);
    end
    rst_dut();
    for (int i = 0; i < 400; i++) cyc($urandom_range(0, 9) < 6, $urandom_range(0, 9) < 5, $urandom);
    rst_dut();
    for (int i = 0; i < 512; i++) cyc(1, 0, $urandom);
    chk("full_512", {31'b0, full}, 1);
    chk("fill_512", {22'b0, fill}, 512);
    cyc(1, 0, 32'h1111_1111);
    chk("ov_513", {31'b0, ov}, 1);
    cyc(1, 1, 32'h2222_2222);
    chk("full_rw_fill", {22'b0, fill}, 511);
    for (int i = 0; i < 511; i++) cyc(0, 1, 0);
    prev = data;
    cyc(1, 1, 32'h5555_5555);
    chk("empty_rw_fill", {22'b0, fill}, 1);
    chk("empty_rw_un", {31'b0, un}, 1);
    chk("empty_rw_data", data, prev);
    for (int i = 0; i < 600; i++) cyc(1, 1, $urandom);
    rst_dut();
    for (int i = 0; i < 3; i++) cyc(1, 0, 32'hA0 + i);
    w_open = 0;
    cyc(0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      chk("eof_early", {31'b0, eof}, 0);
      cyc(0, 1, 0);
    end
    chk("eof_lag", {31'b0, eof}, 0);
    cyc(0, 0, 0);
    chk("eof_set", {31'b0, eof}, 1);
    w_open = 1;
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    chk("eof_clr", {31'b0, eof}, 0);
    rst_dut();
    for (int i = 0; i < 10; i++) cyc(1, 0, $urandom);
    r_open = 0;
    cyc(1, 0, 32'hDEAD_BEEF);
    chk("flush_fill", {22'b0, fill}, 1);
    r_open = 1;
    cyc(0, 0, 0);
    cyc(0, 1, 0);
    chk("flush_data", data, 32'hDEAD_BEEF);
    for (int i = 0; i < 5; i++) cyc(1, 0, $urandom);
    #2 bus_rst = 1'b1;
    #1;
    chk("async_empty", {31'b0, empty}, 1);
    chk("async_fill", {22'b0, fill}, 0);
    #1 bus_rst = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
